// File: rtl/pixel_stream_packer_pkg.sv
// pixel_stream_packer_pkg: shared fixed-point and colour types for the pixel packer
package pixel_stream_packer_pkg;
  localparam int FP_FRAC = 16;
  typedef logic signed [31:0] fp;
  typedef logic [23:0] rgb_t;
  function automatic rgb_t grey(input logic [7:0] v);
    return {v, v, v};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO, push accepted when full if a pop happens in the same cycle
module sync_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [W-1:0]            data_i,
  input  logic                    pop_i,
  output logic [W-1:0]            data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q];
  assign level_o = cnt_q;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage is left uncleared on reset; the count alone defines validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: shades march distances into greyscale pixels and frames them as an AXI stream
module pixel_stream_packer
  import pixel_stream_packer_pkg::*;
#(
  parameter int   WIDTH      = 640,
  parameter int   HEIGHT     = 480,
  parameter int   FIFO_DEPTH = 16,
  parameter fp    MAX_DIST   = fp'(64 * (1 << FP_FRAC)),
  parameter int   DIST_SHIFT = FP_FRAC - 2,
  parameter rgb_t BG_COLOR   = 24'h202040
) (
  input  logic                         clk,
  input  logic                         rst,
  input  fp                            distance,
  input  logic                         valid_in,
  output rgb_t                         m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         frame_done,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  fp sh;
  logic [7:0] idx;
  rgb_t shade, px_q;
  logic sv_q, full, empty, hs, last_x, last_y;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  // distance to colour: closer hits are brighter, misses get the background
  always_comb begin
    sh    = distance >>> DIST_SHIFT;
    idx   = sh < 0 ? 8'd0 : (sh > 255 ? 8'd255 : sh[7:0]);
    shade = distance < MAX_DIST ? grey(8'd255 - idx) : BG_COLOR;
  end
  // shade stage register feeding the FIFO one cycle later
  always_ff @(posedge clk) begin
    sv_q <= rst ? 1'b0 : valid_in;
    if (valid_in) px_q <= shade;
  end
  sync_fifo #(.W(24), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(sv_q), .data_i(px_q), .pop_i(m_axis_tready),
    .data_o(m_axis_tdata), .full_o(full), .empty_o(empty), .level_o(fifo_level)
  );
  assign m_axis_tvalid = ~empty;
  assign hs            = m_axis_tvalid & m_axis_tready;
  assign last_x        = x_q == XW'(WIDTH - 1);
  assign last_y        = y_q == YW'(HEIGHT - 1);
  assign m_axis_tuser  = x_q == '0 && y_q == '0;
  assign m_axis_tlast  = last_x;
  // raster position advances on accepted pixels only; overflow is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= hs & last_x & last_y;
      overflow   <= overflow | (sv_q & full & ~m_axis_tready);
      if (hs) x_q <= last_x ? '0 : x_q + XW'(1);
      if (hs & last_x) y_q <= last_y ? '0 : y_q + YW'(1);
    end
  end
endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb_pixel_stream_packer: randomized and directed checks against a queue-based reference model
module tb_pixel_stream_packer;
  import pixel_stream_packer_pkg::*;
  localparam int W = 4, H = 2, D = 16;
  localparam fp MD = fp'(100 * 65536);
  localparam rgb_t BG = 24'h202040;
  logic clk = 0, rst = 1, valid_in = 0, m_axis_tready = 0;
  fp distance = '0;
  rgb_t m_axis_tdata;
  logic m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, overflow;
  logic [4:0] fifo_level;
  int total = 0, bad = 0, fd_cnt = 0;
  bit chk_en = 0, prev_stall = 0;
  rgb_t prev_data;
  rgb_t log_d[$];
  bit log_u[$], log_l[$];
  rgb_t mq[$];
  bit pend = 0, mov = 0, mfd = 0;
  rgb_t pend_c;
  int mx = 0, my = 0;

  pixel_stream_packer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D), .MAX_DIST(MD), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .distance(distance), .valid_in(valid_in),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .frame_done(frame_done),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rgb_t ref_color(input fp d);
    int idx;
    if (d >= MD) return BG;
    idx = d < 0 ? 0 : int'(d) / 16384;
    if (idx > 255) idx = 255;
    return {3{8'(255 - idx)}};
  endfunction

  function automatic fp rnd();
    return fp'($urandom_range(0, 240 * 65536)) - fp'(120 * 65536);
  endfunction

  // reference: a pixel sampled at one edge enters the buffer at the next
  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); pend = 0; mx = 0; my = 0; mov = 0; mfd = 0;
    end else begin
      mfd = 0;
      if (mq.size() > 0 && m_axis_tready) begin
        void'(mq.pop_front());
        mfd = (mx == W - 1 && my == H - 1);
        if (mx == W - 1) begin mx = 0; my = (my == H - 1) ? 0 : my + 1; end
        else mx++;
      end
      if (pend) begin
        if (mq.size() < D) mq.push_back(pend_c);
        else mov = 1;
      end
      pend = valid_in;
      pend_c = ref_color(distance);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tvalid", m_axis_tvalid, mq.size() > 0);
      chk("level", fifo_level, mq.size());
      chk("overflow", overflow, mov);
      chk("frame_done", frame_done, mfd);
      if (mq.size() > 0) begin
        chk("tdata", m_axis_tdata, mq[0]);
        chk("tuser", m_axis_tuser, mx == 0 && my == 0);
        chk("tlast", m_axis_tlast, mx == W - 1);
      end
      if (prev_stall && !rst) chk("stall_stable", m_axis_tdata, prev_data);
      prev_stall = !rst && m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready && !rst) begin
        log_d.push_back(m_axis_tdata); log_u.push_back(m_axis_tuser); log_l.push_back(m_axis_tlast);
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic cyc(input bit v, input fp d, input bit r);
    @(posedge clk); #1;
    valid_in = v; distance = d; m_axis_tready = r;
  endtask

  task automatic do_rst();
    @(posedge clk); #1; rst = 1; valid_in = 0;
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic drain(input bit toggle);
    int n = 0;
    bit r = 1;
    while ((mq.size() > 0 || pend) && n < 200) begin
      cyc(0, '0, r);
      if (toggle) r = ~r;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 1, 0);
    cyc(0, '0, 1);
    cyc(0, '0, 1);
    cyc(0, '0, 1);
  endtask

  task automatic clear_log();
    log_d.delete(); log_u.delete(); log_l.delete(); fd_cnt = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("ref_zero", ref_color(0), 24'hFFFFFF);
    chk("ref_eight", ref_color(fp'(8 * 65536)), 24'hDFDFDF);
    chk("ref_max", ref_color(MD), BG);

    clear_log();
    for (int i = 0; i < 8; i++) cyc(1, '0, 1);
    drain(0);
    chk("frame_count", log_d.size(), 8);
    for (int i = 0; i < 8 && i < log_d.size(); i++) begin
      chk("frame_data", log_d[i], 24'hFFFFFF);
      chk("frame_tuser", log_u[i], i == 0);
      chk("frame_tlast", log_l[i], i == 3 || i == 7);
    end
    chk("frame_done_pulses", fd_cnt, 1);

    do_rst(); clear_log();
    cyc(1, MD, 1);
    cyc(1, fp'(-65536), 1);
    cyc(1, fp'(300 * 16384), 1);
    cyc(1, fp'(8 * 65536), 1);
    drain(0);
    chk("shade_count", log_d.size(), 4);
    if (log_d.size() == 4) begin
      chk("shade_maxdist", log_d[0], BG);
      chk("shade_negative", log_d[1], 24'hFFFFFF);
      chk("shade_clamp", log_d[2], 24'h000000);
      chk("shade_mid", log_d[3], 24'hDFDFDF);
    end

    do_rst(); clear_log();
    for (int i = 0; i < 16; i++) cyc(1, fp'(i * 65536), 0);
    repeat (3) cyc(0, '0, 0);
    @(negedge clk);
    chk("full_level", fifo_level, 16);
    chk("full_no_overflow", overflow, 0);
    cyc(1, fp'(20 * 65536), 0);
    cyc(0, '0, 1);
    repeat (2) cyc(0, '0, 0);
    @(negedge clk);
    chk("pushpop_level", fifo_level, 16);
    chk("pushpop_overflow", overflow, 0);
    cyc(1, fp'(30 * 65536), 0);
    repeat (3) cyc(0, '0, 0);
    @(negedge clk);
    chk("drop_overflow", overflow, 1);
    chk("drop_level", fifo_level, 16);
    drain(0);
    chk("drop_count", log_d.size(), 17);
    for (int k = 0; k < 17 && k < log_d.size(); k++)
      chk("drop_order", log_d[k], k < 16 ? {3{8'(255 - 4 * k)}} : 24'hAFAFAF);
    chk("overflow_sticky", overflow, 1);

    do_rst(); clear_log();
    for (int i = 0; i < 8; i++) cyc(1, rnd(), i[0]);
    drain(1);
    chk("toggle_count", log_d.size(), 8);
    chk("toggle_frame_done", fd_cnt, 1);

    do_rst(); clear_log();
    for (int i = 0; i < 8; i++) cyc(1, fp'(i * 65536), 0);
    repeat (3) cyc(0, '0, 0);
    repeat (5) cyc(0, '0, 1);
    cyc(0, '0, 0);
    @(negedge clk);
    chk("mid_level", fifo_level, 3);
    chk("mid_count", log_d.size(), 5);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_tvalid", m_axis_tvalid, 0);
    chk("rst_mid_level", fifo_level, 0);
    clear_log();
    cyc(1, '0, 1);
    drain(0);
    chk("after_rst_count", log_d.size(), 1);
    if (log_d.size() > 0) chk("after_rst_tuser", log_u[0], 1);

    do_rst(); clear_log();
    for (int i = 0; i < 3000; i++) cyc($urandom_range(0, 2) != 0, rnd(), $urandom_range(0, 3) != 0);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
